// File: rtl/divider_pkg.sv
// Shared types and constants for the iterative restoring divider.
// Holds the FSM state enum, the step-counter width helper and the divide-by-zero quotient.
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } div_state_e;

    // Wide enough for any practical N; the top slices off the low N bits.
    localparam logic [63:0] DZ_QUOTIENT_ALL = '1;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/divider_step.sv
// One restoring shift-and-subtract step: shifts a dividend bit into the partial
// remainder and subtracts the divisor when it fits.
module divider_step #(
    parameter int N = 8
) (
    input  logic [N-2:0] rem_i,
    input  logic         bit_i,
    input  logic [N-1:0] divisor_i,
    output logic [N-1:0] rem_o,
    output logic         q_bit_o
);

    logic [N-1:0] window;
    logic [N:0]   diff;

    // The partial remainder's top bit is always zero before a shift, so N bits of window suffice.
    always_comb begin
        window  = {rem_i, bit_i};
        diff    = {1'b0, window} - {1'b0, divisor_i};
        q_bit_o = ~diff[N];
        rem_o   = diff[N] ? window : diff[N-1:0];
    end

endmodule

// File: rtl/iterative_divider.sv
// Multi-cycle restoring divider with valid/ready on both sides.
// Signed operation is compiled in only when DIVIDER_SIGNED_EN is defined.
module iterative_divider
    import divider_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic         i_signed,
    input  logic [N-1:0] i_dividend,
    input  logic [N-1:0] i_divisor,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [N-1:0] o_quotient,
    output logic [N-1:0] o_remainder,
    output logic         o_div_by_zero
);

    localparam int CW = cnt_width(N);

    div_state_e   state_q, state_d;
    logic [N-1:0] shreg_q, shreg_d;
    logic [N-1:0] dvsr_q, dvsr_d;
    logic [N-1:0] rem_q, rem_d;
    logic [N-1:0] quot_q, quot_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic         dz_q, dz_d;

    logic [N-1:0] a_mag, b_mag;
    logic [N-1:0] step_rem;
    logic         step_qbit;

`ifdef DIVIDER_SIGNED_EN
    logic sgn_q, sgn_d;
    logic negq_q, negq_d;
    logic negr_q, negr_d;
    logic a_neg, b_neg;

    always_comb begin
        a_neg = i_signed & i_dividend[N-1];
        b_neg = i_signed & i_divisor[N-1];
        a_mag = a_neg ? (-i_dividend) : i_dividend;
        b_mag = b_neg ? (-i_divisor) : i_divisor;
    end
`else
    logic unused_signed;
    assign unused_signed = i_signed;

    always_comb begin
        a_mag = i_dividend;
        b_mag = i_divisor;
    end
`endif

    divider_step #(.N(N)) u_step (
        .rem_i     (rem_q[N-2:0]),
        .bit_i     (shreg_q[N-1]),
        .divisor_i (dvsr_q),
        .rem_o     (step_rem),
        .q_bit_o   (step_qbit)
    );

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            dvsr_q  <= '0;
            rem_q   <= '0;
            quot_q  <= '0;
            cnt_q   <= '0;
            dz_q    <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            sgn_q   <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            dvsr_q  <= dvsr_d;
            rem_q   <= rem_d;
            quot_q  <= quot_d;
            cnt_q   <= cnt_d;
            dz_q    <= dz_d;
`ifdef DIVIDER_SIGNED_EN
            sgn_q   <= sgn_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        dvsr_d  = dvsr_q;
        rem_d   = rem_q;
        quot_d  = quot_q;
        cnt_d   = cnt_q;
        dz_d    = dz_q;
`ifdef DIVIDER_SIGNED_EN
        sgn_d   = sgn_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    dz_d = (i_divisor == '0);
`ifdef DIVIDER_SIGNED_EN
                    sgn_d  = i_signed;
                    negq_d = a_neg ^ b_neg;
                    negr_d = a_neg;
`endif
                    if (i_divisor == '0) begin
                        // Remainder reports the raw dividend bits, signed or not.
                        quot_d  = DZ_QUOTIENT_ALL[N-1:0];
                        rem_d   = i_dividend;
                        state_d = DONE;
                    end else begin
                        shreg_d = a_mag;
                        dvsr_d  = b_mag;
                        rem_d   = '0;
                        quot_d  = '0;
                        cnt_d   = CW'(N);
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                shreg_d = {shreg_q[N-2:0], 1'b0};
                rem_d   = step_rem;
                quot_d  = {quot_q[N-2:0], step_qbit};
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
`ifdef DIVIDER_SIGNED_EN
                    state_d = sgn_q ? FIXUP : DONE;
`else
                    state_d = DONE;
`endif
                end
            end
            FIXUP: begin
`ifdef DIVIDER_SIGNED_EN
                if (negq_q) quot_d = -quot_q;
                if (negr_q) rem_d  = -rem_q;
`endif
                state_d = DONE;
            end
            DONE: begin
                if (i_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_ready       = (state_q == IDLE);
        o_valid       = (state_q == DONE);
        o_quotient    = quot_q;
        o_remainder   = rem_q;
        o_div_by_zero = dz_q;
    end

endmodule

// File: doc/iterative_divider.md
# iterative_divider

Multi-cycle restoring integer divider producing quotient and remainder, with valid/ready handshakes on both operand and result sides. Optional signed mode. Defined divide-by-zero behaviour. Sits between the register file/operand latch and writeback as the datapath's long-latency divide unit. It supersedes the fixed start/finished divider with a flow-controlled, back-pressurable core.

## Interface
Parameters:
- N, 8, operand and result width in bits; legal range N >= 2.

Ports:
- i_clock  in  1  the single clock; all state changes on its rising edge.
- i_reset  in  1  asynchronous, active-high reset; clears all state immediately.
- i_valid  in  1  operand request valid.
- o_ready  out  1  core can accept a request (IDLE only).
- i_signed  in  1  treat operands as two's complement; ignored when DIVIDER_SIGNED_EN is undefined.
- i_dividend  in  N  dividend.
- i_divisor  in  N  divisor.
- o_valid  out  1  result valid; held until accepted.
- i_ready  in  1  consumer accepts result.
- o_quotient  out  N  quotient.
- o_remainder  out  N  remainder.
- o_div_by_zero  out  1  result came from a zero divisor.

## Operation
- FSM states: IDLE, RUN, FIXUP, DONE. Enumeration lives in the package.
- IDLE: o_ready=1. On i_valid & o_ready, capture operands and the signed flag.
  - If divisor==0, go to DONE.
  - Otherwise load |dividend| into the shift register, clear the partial remainder and quotient, load the step counter with N, and go to RUN.
- RUN: one quotient bit per cycle, MSB first.
  - window = {partial_remainder[N-2:0], dividend_msb}. The dividend shifts left.
  - Compute window - |divisor| with N+1-bit subtraction. No borrow: partial_remainder <= difference and quotient bit = 1. Borrow: partial_remainder <= window and quotient bit = 0.
  - Counter decrements. At 0, go to FIXUP if the captured signed flag is set, else DONE.
- FIXUP: negate the quotient if the operand signs differed. Negate the remainder if the dividend was negative. Then go to DONE.
- DONE: o_valid=1. Outputs are stable while o_valid & !i_ready. On i_ready, go to IDLE.
- Divide by zero: quotient = all ones, remainder = dividend (unmodified bits), o_div_by_zero=1. Applies to both signed and unsigned.
- Signed overflow (most-negative / -1): quotient = most-negative, remainder = 0. This falls out of the magnitude arithmetic with no special case.
- Magnitudes are held as N-bit unsigned. The magnitude of most-negative is 2^(N-1) and is representable.
- i_valid while !o_ready is ignored. The requester must hold its operands until the handshake.

## Timing
- Reset values: o_ready=1, o_valid=0, o_quotient=0, o_remainder=0, o_div_by_zero=0. State is IDLE.
- Accept-edge-to-o_valid latency:
  - N+1 clocks for unsigned ops.
  - N+2 clocks for signed ops.
  - 1 clock for divide by zero.
- o_ready drops the cycle after the accept edge and returns the cycle after the result handshake. There is no accept in the same cycle as result retirement.
- Peak throughput: one op per N+2 clocks (unsigned, i_ready tied high).
- o_div_by_zero is valid only with o_valid and is cleared on the next accept.
- i_reset asserted mid-RUN or mid-DONE aborts the op immediately. No result is produced. After release, o_ready=1 on the first clock.

## Configuration
- DIVIDER_SIGNED_EN defined:
  - i_signed is honoured.
  - Absolute-value logic on input, the FIXUP state and the negation logic are present.
- DIVIDER_SIGNED_EN undefined:
  - i_signed is ignored and all ops are unsigned.
  - FIXUP is never entered and the negation logic is absent.
  - Latency is always N+1.

## Structure
- Package divider_pkg holds:
  - the state enum (IDLE, RUN, FIXUP, DONE);
  - a function for counter width, $clog2(N+1);
  - the divide-by-zero quotient constant (all ones).
- One sub-module, divider_step: a combinational shift-and-subtract step. It takes the partial remainder, the incoming dividend bit and the divisor, and returns the next partial remainder and the quotient bit. It is instantiated once.

## Test plan
All values below are for N=8.
- Unsigned 100/7 -> q=14 (0x0E), r=2, dz=0. o_valid exactly 9 clocks after the accept edge.
- Divide by zero: 37/0 -> q=0xFF, r=0x25, dz=1. o_valid 1 clock after the accept edge.
- Signed -7/2 (0xF9/0x02, i_signed=1) -> q=0xFD (-3), r=0xFF (-1), 10-clock latency. Also -128/-1 -> q=0x80, r=0.
- Backpressure: hold i_ready=0 for 5 clocks after o_valid -> outputs stable, o_ready=0 throughout. i_ready=1 -> IDLE next clock and o_ready=1.
- Reset mid-RUN: assert i_reset at RUN step 3 -> all outputs at reset values asynchronously. A new op of 255/16 then yields q=15, r=15.
- Back-to-back: i_valid held high with queued ops 200/3 then 9/9 -> q=66 r=2, then q=1 r=0. Second accept occurs only after the first result handshake.
